// File: rtl/shift_window_buffer.sv
// shift_window_buffer
// Builds vertical tap columns from a row-major pixel stream. Every accepted
// pixel is pushed into a shift chain; the tap column presented downstream
// holds the new pixel plus the pixels j*d rows above it, for j = 1..TAP_NUMBER-1.
// The row dilation d is latched from the first pixel of each frame.
//
// Optional build macro: SHIFT_WINDOW_EARLY_VALID_EN
//   defined   -> a column is produced for every accepted pixel. Lanes whose
//                source pixel lies above the top of the frame read as zero.
//   undefined -> columns start only once the full tap height has been seen.
//
// state  | meaning
// IDLE   | no pixel of the current frame accepted yet (fill count 0)
// FILL   | some pixels accepted, tap column not yet complete
// STREAM | window full, every accept produces a full column

module shift_window_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int TAP_NUMBER   = 3,
    parameter int TILE_WIDTH   = 32,
    parameter int MAX_DILATION = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic [2:0]                       dilation_i,
    input  logic                             s_valid_i,
    output logic                             s_ready_o,
    input  logic [DATA_WIDTH-1:0]            s_data_i,
    output logic                             m_valid_o,
    input  logic                             m_ready_i,
    output logic [TAP_NUMBER*DATA_WIDTH-1:0] m_tap_data_o,
    output logic                             cfg_err_o
);

    localparam int         CHAIN_LEN = (TAP_NUMBER - 1) * MAX_DILATION * TILE_WIDTH;
    localparam int         CNT_W     = $clog2(CHAIN_LEN + 2);
    localparam logic [2:0] MAX_DIL_3 = 3'(MAX_DILATION);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [CNT_W-1:0]                  cnt_post;
    logic [CNT_W-1:0]                  required;
    logic [2:0]                        dil_q, dil_d;
    logic [2:0]                        dil_use;
    logic                              dil_legal;
    logic                              cfg_err_q, cfg_err_d;
    logic                              valid_q, valid_d;
    logic [TAP_NUMBER*DATA_WIDTH-1:0]  tap_q, tap_d;
    logic                              accept;

    logic [DATA_WIDTH-1:0]             chain_q [CHAIN_LEN];
    logic [DATA_WIDTH-1:0]             lane_src [TAP_NUMBER];

    // A new pixel can enter whenever the output slot is free or being drained.
    assign s_ready_o = (!valid_q || m_ready_i) && !clear && !rst;
    assign accept    = s_valid_i && s_ready_o;
    assign dil_legal = (dilation_i != 3'd0) && (dilation_i <= MAX_DIL_3);

    // Dilation in force for the current accept: sampled in IDLE, latched otherwise.
    always_comb begin
        dil_use = dil_q;
        if (state_q == IDLE) begin
            dil_use = dil_legal ? dilation_i : 3'd1;
        end
    end

    // Fill target for the active dilation and the saturating post-accept count.
    always_comb begin
        required = CNT_W'((TAP_NUMBER - 1) * TILE_WIDTH * int'(dil_use) + 1);
        cnt_post = (cnt_q == required) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Pick the pixel j*d rows back for each upper lane; lane 0 is the incoming pixel.
    always_comb begin
        for (int j = 0; j < TAP_NUMBER; j++) begin
            lane_src[j] = '0;
        end
        lane_src[0] = s_data_i;
        for (int j = 1; j < TAP_NUMBER; j++) begin
            lane_src[j] = chain_q[j * TILE_WIDTH - 1];
            for (int dd = 2; dd <= MAX_DILATION; dd++) begin
                if (dil_use == 3'(dd)) begin
                    lane_src[j] = chain_q[j * dd * TILE_WIDTH - 1];
                end
            end
        end
    end

    // Next tap column: loaded on accept, otherwise held so it stays stable under backpressure.
    always_comb begin
        tap_d = tap_q;
        if (accept) begin
            for (int j = 0; j < TAP_NUMBER; j++) begin
`ifdef SHIFT_WINDOW_EARLY_VALID_EN
                // Source pixel above the frame top: pad with zero.
                if ((j * TILE_WIDTH * int'(dil_use)) >= int'(cnt_post)) begin
                    tap_d[j*DATA_WIDTH +: DATA_WIDTH] = '0;
                end else begin
                    tap_d[j*DATA_WIDTH +: DATA_WIDTH] = lane_src[j];
                end
`else
                tap_d[j*DATA_WIDTH +: DATA_WIDTH] = lane_src[j];
`endif
            end
        end
    end

    // Frame sequencing: fill count, state, dilation latch, error flag and output valid.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dil_d     = dil_q;
        cfg_err_d = cfg_err_q;
        valid_d   = valid_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            cnt_d   = cnt_post;
            state_d = (cnt_post == required) ? STREAM : FILL;
            if (state_q == IDLE) begin
                dil_d = dil_use;
                if (!dil_legal) begin
                    cfg_err_d = 1'b1;
                end
            end
`ifdef SHIFT_WINDOW_EARLY_VALID_EN
            valid_d = 1'b1;
`else
            valid_d = (cnt_post == required);
`endif
        end else if (m_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dil_q     <= 3'd1;
            cfg_err_q <= 1'b0;
            valid_q   <= 1'b0;
            tap_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dil_q     <= dil_d;
            cfg_err_q <= cfg_err_d;
            valid_q   <= valid_d;
            tap_q     <= tap_d;
        end
    end

    // Pixel history; contents are only meaningful up to the fill count, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            chain_q[0] <= s_data_i;
            for (int k = 1; k < CHAIN_LEN; k++) begin
                chain_q[k] <= chain_q[k-1];
            end
        end
    end

    assign m_valid_o    = valid_q;
    assign m_tap_data_o = tap_q;
    assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_shift_window_buffer.sv
// Directed bench for shift_window_buffer (DATA_WIDTH=16, TILE_WIDTH=32, TAP_NUMBER=3).
// Pixel values equal their index within the frame plus a per-frame base.
module tb_shift_window_buffer;

    localparam int DW   = 16;
    localparam int TW   = 32;
    localparam int TAP  = 3;
    localparam int MAXD = 4;

    logic             clk;
    logic             rst;
    logic             clear;
    logic [2:0]       dilation_i;
    logic             s_valid_i;
    logic             s_ready_o;
    logic [DW-1:0]    s_data_i;
    logic             m_valid_o;
    logic             m_ready_i;
    logic [TAP*DW-1:0] m_tap_data_o;
    logic             cfg_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    shift_window_buffer #(
        .DATA_WIDTH  (DW),
        .TAP_NUMBER  (TAP),
        .TILE_WIDTH  (TW),
        .MAX_DILATION(MAXD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .dilation_i  (dilation_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_tap_data_o(m_tap_data_o),
        .cfg_err_o   (cfg_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected column for the pixel at frame index idx: lane j = pixel idx-j*d*TW,
    // zero when that pixel lies above the frame.
    function automatic logic [TAP*DW-1:0] exp_col(input int idx, input int d, input int base);
        logic [TAP*DW-1:0] c;
        int off;
        c = '0;
        for (int j = 0; j < TAP; j++) begin
            off = j * d * TW;
            if (off <= idx) c[j*DW +: DW] = 16'(base + idx - off);
        end
        return c;
    endfunction

    function automatic logic exp_valid(input int idx, input int d);
`ifdef SHIFT_WINDOW_EARLY_VALID_EN
        return 1'b1;
`else
        return (idx >= (TAP - 1) * d * TW) ? 1'b1 : 1'b0;
`endif
    endfunction

    // Apply inputs for one cycle, report whether the handshake fires, then sample after the edge.
    task automatic cycle(input logic v, input int data, input logic rdy, input logic clr,
                         output logic acc);
        s_valid_i = v;
        s_data_i  = 16'(data);
        m_ready_i = rdy;
        clear     = clr;
        #1;
        acc = s_valid_i && s_ready_o;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        clear     = 1'b0;
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        clear      = 1'b0;
        s_valid_i  = 1'b1;
        s_data_i   = 16'h1234;
        m_ready_i  = 1'b1;
        dilation_i = 3'd1;
        #1;
        n_checks++;
        if (s_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_s_ready: got %b expected 0", s_ready_o);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (m_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid_o);
        end
        n_checks++;
        if (m_tap_data_o !== '0) begin
            n_fail++; $display("FAIL reset_tap_data: got %h expected 0", m_tap_data_o);
        end
        n_checks++;
        if (cfg_err_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err_o);
        end
        rst       = 1'b0;
        s_valid_i = 1'b0;
    endtask

    // Stream npix pixels with m_ready_i high; dilation_i changes to dil_mid after pixel 10.
    task automatic test_stream(input int dil_first, input int dil_mid, input int d_eff,
                               input int npix);
        int   cols, first, exp_cols, exp_first;
        logic acc, exp_err;
        do_reset();
        cols       = 0;
        first      = -1;
        dilation_i = 3'(dil_first);
        for (int p = 0; p < npix; p++) begin
            if (p == 10) dilation_i = 3'(dil_mid);
            cycle(1'b1, p, 1'b1, 1'b0, acc);
            n_checks++;
            if (acc !== 1'b1) begin
                n_fail++; $display("FAIL stream_accept d=%0d p=%0d: got %b expected 1", d_eff, p, acc);
            end
            n_checks++;
            if (m_valid_o !== exp_valid(p, d_eff)) begin
                n_fail++; $display("FAIL stream_valid d=%0d p=%0d: got %b expected %b",
                                   d_eff, p, m_valid_o, exp_valid(p, d_eff));
            end
            if (m_valid_o === 1'b1) begin
                cols++;
                if (first < 0) first = p;
                n_checks++;
                if (m_tap_data_o !== exp_col(p, d_eff, 0)) begin
                    n_fail++; $display("FAIL stream_lanes d=%0d p=%0d: got %h expected %h",
                                       d_eff, p, m_tap_data_o, exp_col(p, d_eff, 0));
                end
            end
        end
`ifdef SHIFT_WINDOW_EARLY_VALID_EN
        exp_cols  = npix;
        exp_first = 0;
`else
        exp_cols  = npix - (TAP - 1) * d_eff * TW;
        exp_first = (TAP - 1) * d_eff * TW;
`endif
        n_checks++;
        if (cols !== exp_cols) begin
            n_fail++; $display("FAIL stream_columns d=%0d: got %0d expected %0d", d_eff, cols, exp_cols);
        end
        n_checks++;
        if (first !== exp_first) begin
            n_fail++; $display("FAIL stream_first d=%0d: got %0d expected %0d", d_eff, first, exp_first);
        end
        exp_err = (dil_first == 0 || dil_first > MAXD) ? 1'b1 : 1'b0;
        n_checks++;
        if (cfg_err_o !== exp_err) begin
            n_fail++; $display("FAIL stream_cfg_err d=%0d: got %b expected %b", d_eff, cfg_err_o, exp_err);
        end
        s_valid_i = 1'b0;
    endtask

    // Stall the output for 5 cycles, then drain under an irregular m_ready_i pattern.
    task automatic test_back_to_back();
        logic              acc, rdy;
        logic [TAP*DW-1:0] held, prev;
        int                nxt;
        do_reset();
        dilation_i = 3'd1;
        for (int p = 0; p < 70; p++) cycle(1'b1, p, 1'b1, 1'b0, acc);
        held = m_tap_data_o;
        n_checks++;
        if (held !== exp_col(69, 1, 0)) begin
            n_fail++; $display("FAIL bp_before_stall: got %h expected %h", held, exp_col(69, 1, 0));
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 70, 1'b0, 1'b0, acc);
            n_checks++;
            if (acc !== 1'b0) begin
                n_fail++; $display("FAIL bp_s_ready cycle=%0d: got %b expected 0", i, acc);
            end
            n_checks++;
            if (m_tap_data_o !== held || m_valid_o !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold cycle=%0d: got %h/%b expected %h/1",
                                   i, m_tap_data_o, m_valid_o, held);
            end
        end
        nxt = 70;
        for (int i = 0; i < 40; i++) begin
            rdy  = ((i % 3) != 2) ? 1'b1 : 1'b0;
            prev = m_tap_data_o;
            cycle(1'b1, nxt, rdy, 1'b0, acc);
            n_checks++;
            if (acc !== rdy) begin
                n_fail++; $display("FAIL bp_accept i=%0d: got %b expected %b", i, acc, rdy);
            end
            n_checks++;
            if (m_valid_o !== 1'b1) begin
                n_fail++; $display("FAIL bp_valid i=%0d: got %b expected 1", i, m_valid_o);
            end
            n_checks++;
            if (acc) begin
                if (m_tap_data_o !== exp_col(nxt, 1, 0)) begin
                    n_fail++; $display("FAIL bp_lanes pix=%0d: got %h expected %h",
                                       nxt, m_tap_data_o, exp_col(nxt, 1, 0));
                end
                nxt++;
            end else if (m_tap_data_o !== prev) begin
                n_fail++; $display("FAIL bp_stable i=%0d: got %h expected %h", i, m_tap_data_o, prev);
            end
        end
        n_checks++;
        if (nxt !== 97) begin
            n_fail++; $display("FAIL bp_pixel_count: got %0d expected 97", nxt);
        end
        s_valid_i = 1'b0;
    endtask

    // Clear after pixel 80 with a pixel offered; restart frame with base 1000.
    task automatic test_clear();
        logic acc;
        do_reset();
        dilation_i = 3'd5;
        for (int p = 0; p <= 80; p++) cycle(1'b1, p, 1'b1, 1'b0, acc);
        n_checks++;
        if (m_valid_o !== 1'b1 || m_tap_data_o !== exp_col(80, 1, 0)) begin
            n_fail++; $display("FAIL clr_before: got %b/%h expected 1/%h",
                               m_valid_o, m_tap_data_o, exp_col(80, 1, 0));
        end
        dilation_i = 3'd1;
        cycle(1'b1, 81, 1'b1, 1'b1, acc);
        n_checks++;
        if (acc !== 1'b0) begin
            n_fail++; $display("FAIL clr_s_ready: got %b expected 0", acc);
        end
        n_checks++;
        if (m_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL clr_m_valid: got %b expected 0", m_valid_o);
        end
        n_checks++;
        if (cfg_err_o !== 1'b1) begin
            n_fail++; $display("FAIL clr_cfg_err_kept: got %b expected 1", cfg_err_o);
        end
        for (int k = 0; k <= 64; k++) begin
            cycle(1'b1, 1000 + k, 1'b1, 1'b0, acc);
            n_checks++;
            if (m_valid_o !== exp_valid(k, 1)) begin
                n_fail++; $display("FAIL clr_restart_valid k=%0d: got %b expected %b",
                                   k, m_valid_o, exp_valid(k, 1));
            end
            if (m_valid_o === 1'b1) begin
                n_checks++;
                if (m_tap_data_o !== exp_col(k, 1, 1000)) begin
                    n_fail++; $display("FAIL clr_restart_lanes k=%0d: got %h expected %h",
                                       k, m_tap_data_o, exp_col(k, 1, 1000));
                end
            end
        end
        s_valid_i = 1'b0;
    endtask

    // Reset in the middle of a frame discards history and clears the error flag.
    task automatic test_reset_midstream();
        logic acc;
        do_reset();
        dilation_i = 3'd0;
        for (int p = 0; p < 70; p++) cycle(1'b1, p, 1'b1, 1'b0, acc);
        n_checks++;
        if (cfg_err_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_err_set: got %b expected 1", cfg_err_o);
        end
        rst       = 1'b1;
        s_valid_i = 1'b1;
        m_ready_i = 1'b1;
        #1;
        n_checks++;
        if (s_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_s_ready: got %b expected 0", s_ready_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (m_valid_o !== 1'b0 || m_tap_data_o !== '0 || cfg_err_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %b/%h/%b expected 0/0/0",
                               m_valid_o, m_tap_data_o, cfg_err_o);
        end
        dilation_i = 3'd1;
        for (int k = 0; k <= 64; k++) begin
            cycle(1'b1, 500 + k, 1'b1, 1'b0, acc);
            n_checks++;
            if (m_valid_o !== exp_valid(k, 1)) begin
                n_fail++; $display("FAIL rstmid_valid k=%0d: got %b expected %b",
                                   k, m_valid_o, exp_valid(k, 1));
            end
        end
        n_checks++;
        if (m_tap_data_o !== exp_col(64, 1, 500)) begin
            n_fail++; $display("FAIL rstmid_lanes: got %h expected %h", m_tap_data_o, exp_col(64, 1, 500));
        end
        s_valid_i = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        clear      = 1'b0;
        dilation_i = 3'd1;
        s_valid_i  = 1'b0;
        s_data_i   = '0;
        m_ready_i  = 1'b1;
        test_reset();
        test_stream(1, 1, 1, 100);
        test_stream(2, 2, 2, 140);
        test_stream(4, 4, 4, 270);
        test_stream(5, 2, 1, 100);
        test_back_to_back();
        test_clear();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
